// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder.
package dvi_pkg;

    localparam int TMDS_W = 10;
    localparam int DISP_W = 6;

    // Control tokens sent during blanking, indexed by {c1, c0}.
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_0 = 10'h354;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_1 = 10'h0AB;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_2 = 10'h154;
    localparam logic [TMDS_W-1:0] CTRL_TOKEN_3 = 10'h2AB;

    // Which of the three DC-balancing rules applies to the current word.
    typedef enum logic [1:0] {
        ENC_BAL,   // disparity neutral: choose polarity from q_m[8]
        ENC_INV,   // word would push disparity further: invert it
        ENC_PASS   // word pulls disparity back: send it as is
    } enc_case_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [TMDS_W-1:0] ctrl_token(input logic [1:0] c);
        logic [TMDS_W-1:0] t;
        case (c)
            2'b00:   t = CTRL_TOKEN_0;
            2'b01:   t = CTRL_TOKEN_1;
            2'b10:   t = CTRL_TOKEN_2;
            default: t = CTRL_TOKEN_3;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/dvi_tmds_encoder_if.sv
// Display-side bundle: incoming pixel/sync signals and outgoing TMDS symbols.
interface dvi_tmds_encoder_if #(
    parameter int BPC = 5
);
    logic [BPC-1:0]              disp_r;
    logic [BPC-1:0]              disp_g;
    logic [BPC-1:0]              disp_b;
    logic                        disp_hsync;
    logic                        disp_vsync;
    logic                        disp_de;
    logic [dvi_pkg::TMDS_W-1:0]  tmds_ch0;
    logic [dvi_pkg::TMDS_W-1:0]  tmds_ch1;
    logic [dvi_pkg::TMDS_W-1:0]  tmds_ch2;

    // Display controller side: drives pixels, observes symbols.
    modport master (
        output disp_r, disp_g, disp_b, disp_hsync, disp_vsync, disp_de,
        input  tmds_ch0, tmds_ch1, tmds_ch2
    );

    // Encoder side: consumes pixels, produces symbols.
    modport slave (
        input  disp_r, disp_g, disp_b, disp_hsync, disp_vsync, disp_de,
        output tmds_ch0, tmds_ch1, tmds_ch2
    );
endinterface

// File: rtl/dvi_tmds_encoder_channel.sv
// One TMDS lane: transition-minimising stage, then DC-balancing stage with
// its own running disparity. Two register stages, no stall.
module tmds_channel
    import dvi_pkg::*;
(
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic [7:0]        d,
    input  logic              de,
    input  logic [1:0]        ctrl,
    output logic [TMDS_W-1:0] q
);

    logic [3:0]              w_n1;
    logic                    w_use_xnor;
    logic [8:0]              w_qm;

    logic [8:0]              r_qm;
    logic                    r_de;
    logic [1:0]              r_ctrl;

    logic [3:0]              w_n1q;
    logic [DISP_W-1:0]       w_bal;      // N1q - N0q, two's complement
    logic [DISP_W-1:0]       w_two_q8;   // 2*q_m[8]
    logic [DISP_W-1:0]       w_two_nq8;  // 2*~q_m[8]
    enc_case_t               w_case;
    logic [TMDS_W-1:0]       w_sym;
    logic [DISP_W-1:0]       w_cnt_next;

    logic [TMDS_W-1:0]       r_q;
    logic [DISP_W-1:0]       r_cnt;

    assign w_n1       = popcount8(d);
    assign w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !d[0]);

    // The XOR/XNOR chain unrolled: bit i is the parity of d[i:0], and each
    // XNOR step adds one extra inversion, so odd bits flip in XNOR mode.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_qm
            assign w_qm[gi] = (^d[gi:0]) ^ (w_use_xnor && ((gi % 2) == 1));
        end
    endgenerate
    assign w_qm[8] = ~w_use_xnor;

    // Stage 1 register: minimised word plus aligned de/ctrl.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_qm   <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_de   <= de;
            r_ctrl <= ctrl;
        end
    end

    assign w_n1q     = popcount8(r_qm[7:0]);
    assign w_bal     = {1'b0, w_n1q, 1'b0} - DISP_W'(8);
    assign w_two_q8  = {{(DISP_W-2){1'b0}}, r_qm[8], 1'b0};
    assign w_two_nq8 = {{(DISP_W-2){1'b0}}, ~r_qm[8], 1'b0};

    // Pick the balancing rule. Outside the neutral case both cnt and the
    // word balance are non-zero, so "same sign" means inversion is needed.
    always_comb begin
        w_case = ENC_PASS;
        if ((r_cnt == '0) || (w_n1q == 4'd4)) begin
            w_case = ENC_BAL;
        end else if (r_cnt[DISP_W-1] == w_bal[DISP_W-1]) begin
            w_case = ENC_INV;
        end
    end

    // Build the output symbol and next disparity; blanking sends a token
    // and clears disparity so each active run starts balanced.
    always_comb begin
        w_sym      = ctrl_token(r_ctrl);
        w_cnt_next = '0;
        if (r_de) begin
            case (w_case)
                ENC_BAL: begin
                    w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                    w_cnt_next = r_qm[8] ? (r_cnt + w_bal) : (r_cnt - w_bal);
                end
                ENC_INV: begin
                    w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
                    w_cnt_next = r_cnt + w_two_q8 - w_bal;
                end
                default: begin
                    w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
                    w_cnt_next = r_cnt + w_bal - w_two_nq8;
                end
            endcase
        end
    end

    // Stage 2 register: output symbol and running disparity.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_q   <= CTRL_TOKEN_0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_sym;
            r_cnt <= w_cnt_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: widens colours to 8 bits, routes sync into the
// blue lane's control bits and runs three independent lanes.
module dvi_tmds_encoder
    import dvi_pkg::*;
#(
    parameter int BPC = 5
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix_n,
    dvi_tmds_encoder_if.slave    disp
);

    logic [BPC-1:0]    w_c    [3];
    logic [7:0]        w_d    [3];
    logic [1:0]        w_ctrl [3];
    logic [TMDS_W-1:0] w_q    [3];

    assign w_c[0] = disp.disp_b;
    assign w_c[1] = disp.disp_g;
    assign w_c[2] = disp.disp_r;

    assign w_ctrl[0] = {disp.disp_vsync, disp.disp_hsync};
    assign w_ctrl[1] = 2'b00;
    assign w_ctrl[2] = 2'b00;

    // Widen by repeating the colour MSB-first until 8 bits are filled.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            for (gj = 0; gj < 8; gj++) begin : g_bit
                assign w_d[gi][7-gj] = w_c[gi][BPC-1-(gj % BPC)];
            end

            tmds_channel u_ch (
                .clk_pix   (clk_pix),
                .rst_pix_n (rst_pix_n),
                .d         (w_d[gi]),
                .de        (disp.disp_de),
                .ctrl      (w_ctrl[gi]),
                .q         (w_q[gi])
            );
        end
    endgenerate

    assign disp.tmds_ch0 = w_q[0];
    assign disp.tmds_ch1 = w_q[1];
    assign disp.tmds_ch2 = w_q[2];

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: BPC=5 and BPC=8 instances side by side,
// table vectors, reset sequences and a reference-model random sweep.
module tb_dvi_tmds_encoder;

    logic clk_pix   = 1'b0;
    logic rst_pix_n = 1'b0;
    always #5 clk_pix = ~clk_pix;

    dvi_tmds_encoder_if #(.BPC(5)) if5 ();
    dvi_tmds_encoder_if #(.BPC(8)) if8 ();

    dvi_tmds_encoder #(.BPC(5)) dut5 (.clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp(if5));
    dvi_tmds_encoder #(.BPC(8)) dut8 (.clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .disp(if8));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        de;
        logic [29:0] e5;    // {ch2, ch1, ch0}
        logic [29:0] e8;
        logic [23:0] px5;   // expanded {r, g, b}
        logic [23:0] px8;
    } sb_t;
    sb_t sb[$];

    typedef struct packed {
        logic        de, vs, hs;
        logic [4:0]  r, g, b;
        logic [29:0] exp_sym;
    } vec_t;
    vec_t tab[15];

    int m_cnt [6];   // reference disparity: 0..2 for BPC=5, 3..5 for BPC=8
    int dsum5 [3];   // disparity recomputed from emitted symbols
    int dsum8 [3];

    localparam logic [29:0] ALL_354 = {10'h354, 10'h354, 10'h354};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [7:0] exp5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // Behavioural DVI 1.0 encoder using plain integer disparity.
    function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d,
                                             input logic de, input logic [1:0] ctrl);
        logic [7:0] qm;
        logic       q8, xn;
        int         n1, n1q, n0q;
        logic [9:0] s;
        if (!de) begin
            m_cnt[ch] = 0;
            case (ctrl)
                2'b00:   s = 10'h354;
                2'b01:   s = 10'h0AB;
                2'b10:   s = 10'h154;
                default: s = 10'h2AB;
            endcase
            return s;
        end
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += (d[i] ? 1 : 0);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = ~xn;
        n1q = 0;
        for (int i = 0; i < 8; i++) n1q += (qm[i] ? 1 : 0);
        n0q = 8 - n1q;
        if (m_cnt[ch] == 0 || n1q == n0q) begin
            s = {~q8, q8, q8 ? qm : ~qm};
            m_cnt[ch] += q8 ? (n1q - n0q) : (n0q - n1q);
        end else if ((m_cnt[ch] > 0 && n1q > n0q) || (m_cnt[ch] < 0 && n0q > n1q)) begin
            s = {1'b1, q8, ~qm};
            m_cnt[ch] += (q8 ? 2 : 0) + n0q - n1q;
        end else begin
            s = {1'b0, q8, qm};
            m_cnt[ch] += n1q - n0q - (q8 ? 0 : 2);
        end
        return s;
    endfunction

    // Receiver-side decode of a data symbol.
    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] b, o;
        b = s[7:0] ^ {8{s[9]}};
        o[0] = b[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        return o;
    endfunction

    function automatic int bal10(input logic [9:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += (s[i] ? 1 : 0);
        return 2 * n - 10;
    endfunction

    function automatic vec_t mk(input logic de, vs, hs, input logic [4:0] r, g, b,
                                input logic [9:0] e2, e1, e0);
        vec_t v;
        v.de = de; v.vs = vs; v.hs = hs;
        v.r = r; v.g = g; v.b = b;
        v.exp_sym = {e2, e1, e0};
        return v;
    endfunction

    task automatic check_out();
        sb_t         e;
        logic [29:0] a5, a8;
        int          d5, d8;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            return;
        end
        e  = sb.pop_front();
        a5 = {if5.tmds_ch2, if5.tmds_ch1, if5.tmds_ch0};
        a8 = {if8.tmds_ch2, if8.tmds_ch1, if8.tmds_ch0};
        chk("sym_bpc5", {2'b00, a5}, {2'b00, e.e5});
        chk("sym_bpc8", {2'b00, a8}, {2'b00, e.e8});
        for (int ch = 0; ch < 3; ch++) begin
            if (e.de) begin
                chk("decode_bpc5", {24'h0, dec(a5[ch*10 +: 10])}, {24'h0, e.px5[ch*8 +: 8]});
                chk("decode_bpc8", {24'h0, dec(a8[ch*10 +: 10])}, {24'h0, e.px8[ch*8 +: 8]});
                dsum5[ch] += bal10(a5[ch*10 +: 10]);
                dsum8[ch] += bal10(a8[ch*10 +: 10]);
                d5 = dsum5[ch];
                d8 = dsum8[ch];
                chk("disparity_bound_bpc5", (d5 <= 10 && d5 >= -10) ? 32'd1 : 32'd0, 32'd1);
                chk("disparity_bound_bpc8", (d8 <= 10 && d8 >= -10) ? 32'd1 : 32'd0, 32'd1);
            end else begin
                dsum5[ch] = 0;
                dsum8[ch] = 0;
            end
        end
    endtask

    // Drive one pixel, queue its expectation, then check the symbol from
    // the pixel driven one cycle earlier (two-edge pipeline).
    task automatic step(input logic de, vs, hs, input logic [4:0] r5, g5, b5,
                        input logic [7:0] r8, g8, b8, input bit use_tab,
                        input logic [29:0] tab_exp);
        sb_t         e;
        logic [29:0] m5, m8;
        if5.disp_de = de; if5.disp_vsync = vs; if5.disp_hsync = hs;
        if5.disp_r = r5;  if5.disp_g = g5;     if5.disp_b = b5;
        if8.disp_de = de; if8.disp_vsync = vs; if8.disp_hsync = hs;
        if8.disp_r = r8;  if8.disp_g = g8;     if8.disp_b = b8;
        m5 = {model_enc(2, exp5(r5), de, 2'b00), model_enc(1, exp5(g5), de, 2'b00),
              model_enc(0, exp5(b5), de, {vs, hs})};
        m8 = {model_enc(5, r8, de, 2'b00), model_enc(4, g8, de, 2'b00),
              model_enc(3, b8, de, {vs, hs})};
        e.de  = de;
        e.px5 = {exp5(r5), exp5(g5), exp5(b5)};
        e.px8 = {r8, g8, b8};
        e.e5  = use_tab ? tab_exp : m5;
        e.e8  = use_tab ? tab_exp : m8;
        sb.push_back(e);
        @(posedge clk_pix);
        #1;
        check_out();
    endtask

    task automatic drive_random();
        if5.disp_de = 1'($urandom); if5.disp_vsync = 1'($urandom); if5.disp_hsync = 1'($urandom);
        if5.disp_r = 5'($urandom); if5.disp_g = 5'($urandom); if5.disp_b = 5'($urandom);
        if8.disp_de = 1'($urandom); if8.disp_vsync = 1'($urandom); if8.disp_hsync = 1'($urandom);
        if8.disp_r = 8'($urandom); if8.disp_g = 8'($urandom); if8.disp_b = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string nm5, input string nm8);
        chk(nm5, {2'b00, if5.tmds_ch2, if5.tmds_ch1, if5.tmds_ch0}, {2'b00, ALL_354});
        chk(nm8, {2'b00, if8.tmds_ch2, if8.tmds_ch1, if8.tmds_ch0}, {2'b00, ALL_354});
    endtask

    // After reset release the cleared pipeline emits one more token 354.
    task automatic release_reset();
        sb_t p;
        #2;
        rst_pix_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        for (int i = 0; i < 3; i++) begin dsum5[i] = 0; dsum8[i] = 0; end
        p.de = 1'b0; p.e5 = ALL_354; p.e8 = ALL_354; p.px5 = '0; p.px8 = '0;
        sb.push_back(p);
    endtask

    task automatic random_run(input int n);
        logic       de, vs, hs;
        logic [4:0] r5, g5, b5;
        for (int i = 0; i < n; i++) begin
            de = ($urandom_range(0, 7) != 0);
            vs = 1'($urandom); hs = 1'($urandom);
            r5 = 5'($urandom); g5 = 5'($urandom); b5 = 5'($urandom);
            step(de, vs, hs, r5, g5, b5, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0);
        end
    endtask

    initial begin
        tab[0]  = mk(0, 0, 0, 5'h15, 5'h0A, 5'h1F, 10'h354, 10'h354, 10'h354);
        tab[1]  = mk(0, 0, 1, 5'h03, 5'h11, 5'h07, 10'h354, 10'h354, 10'h0AB);
        tab[2]  = mk(0, 1, 0, 5'h1F, 5'h1F, 5'h1F, 10'h354, 10'h354, 10'h154);
        tab[3]  = mk(0, 1, 1, 5'h00, 5'h00, 5'h00, 10'h354, 10'h354, 10'h2AB);
        tab[4]  = mk(0, 0, 0, 5'h09, 5'h12, 5'h1C, 10'h354, 10'h354, 10'h354);
        tab[5]  = mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 10'h100, 10'h100, 10'h100);
        tab[6]  = mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 10'h3FF, 10'h3FF, 10'h3FF);
        tab[7]  = mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 10'h100, 10'h100, 10'h100);
        tab[8]  = mk(0, 0, 0, 5'h00, 5'h00, 5'h00, 10'h354, 10'h354, 10'h354);
        tab[9]  = mk(1, 0, 0, 5'h1F, 5'h1F, 5'h1F, 10'h200, 10'h200, 10'h200);
        tab[10] = mk(1, 0, 0, 5'h1F, 5'h1F, 5'h1F, 10'h0FF, 10'h0FF, 10'h0FF);
        tab[11] = mk(0, 0, 0, 5'h00, 5'h00, 5'h00, 10'h354, 10'h354, 10'h354);
        tab[12] = mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 10'h100, 10'h100, 10'h100);
        tab[13] = mk(0, 0, 0, 5'h00, 5'h00, 5'h00, 10'h354, 10'h354, 10'h354);
        tab[14] = mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 10'h100, 10'h100, 10'h100);

        // Reset held with random inputs: outputs stay at the blank token.
        rst_pix_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_random();
            @(posedge clk_pix);
            #1;
            check_reset_outputs("reset_hold_bpc5", "reset_hold_bpc8");
        end
        release_reset();

        // Table vectors: blanking tokens, black/white runs, disparity reset.
        for (int i = 0; i < 15; i++) begin
            step(tab[i].de, tab[i].vs, tab[i].hs, tab[i].r, tab[i].g, tab[i].b,
                 exp5(tab[i].r), exp5(tab[i].g), exp5(tab[i].b), 1'b1, tab[i].exp_sym);
        end

        random_run(5000);

        // Mid-frame reset: outputs must fall to 354 before the next edge.
        #2;
        rst_pix_n = 1'b0;
        #1;
        check_reset_outputs("reset_async_bpc5", "reset_async_bpc8");
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk_pix);
            #1;
            check_reset_outputs("reset_mid_hold_bpc5", "reset_mid_hold_bpc8");
        end
        release_reset();

        random_run(5000);
        step(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
